// File: rtl/dma_agen_nd_pkg.sv
// ----------------------------------------------------------------------------
// dma_agen_nd_pkg
// Shared definitions for the N-dimensional DMA address generator:
//   state_t   - job controller states (IDLE: waiting for a job, RUN: beats out)
//   NDIM_MIN  - smallest supported loop dimension count
//   NDIM_MAX  - largest supported loop dimension count
// ----------------------------------------------------------------------------
package dma_agen_nd_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int NDIM_MIN = 1;
    localparam int NDIM_MAX = 4;

endpackage

// File: rtl/dma_agen_nd_dim_cnt.sv
// ----------------------------------------------------------------------------
// dma_dim_cnt
// Index counter for one loop dimension. Counts 0..size-1 and wraps to 0; the
// parent chains advance enables so a wrap here carries into the next dim.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - synchronous restart at index 0 (new job)
//   adv       - advance this dimension by one index this cycle
//   size      - latched element count for this dimension (nonzero in use)
//   at_first  - index is 0
//   at_last   - index is size-1 (a size of 1 is both first and last)
// ----------------------------------------------------------------------------
module dma_dim_cnt
    import dma_agen_nd_pkg::*;
#(
    parameter int SZW = 7
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    input  logic           adv,
    input  logic [SZW-1:0] size,
    output logic           at_first,
    output logic           at_last
);

    logic [SZW-1:0] idx;

    assign at_first = (idx == '0);
    assign at_last  = (idx == size - SZW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (adv) begin
            idx <= at_last ? '0 : idx + SZW'(1);
        end
    end

endmodule

// File: rtl/dma_agen_nd.sv
// ----------------------------------------------------------------------------
// dma_agen_nd
// N-dimensional DMA address generator. Accepts a job (base address, per-dim
// sizes and signed steps, info tag) and streams one address beat per
// accepted handshake, walking dim 0 innermost.
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   base, dim_size, dim_step  - job description (dim d at [d*W +: W])
//   m_info                    - job tag, echoed on s_info
//   start_valid/start_ready   - job handshake (ready only when idle)
//   s_addr, s_info            - beat address and tag
//   s_first, s_last           - bit d: dims 0..d all at first / last index
//   s_valid/s_ready           - beat handshake
//   abort                     - cancel the running job
//   busy, done                - job running; one-cycle end/abort pulse
// ----------------------------------------------------------------------------
module dma_agen_nd
    import dma_agen_nd_pkg::*;
#(
    parameter int AW   = 14,
    parameter int IFW  = 4,
    parameter int NDIM = 3,
    parameter int SZW  = 7,
    parameter int STW  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [AW-1:0]       base,
    input  logic [NDIM*SZW-1:0] dim_size,
    input  logic [NDIM*STW-1:0] dim_step,
    input  logic [IFW-1:0]      m_info,
    input  logic                start_valid,
    output logic                start_ready,
    output logic [AW-1:0]       s_addr,
    output logic [IFW-1:0]      s_info,
    output logic [NDIM-1:0]     s_first,
    output logic [NDIM-1:0]     s_last,
    output logic                s_valid,
    input  logic                s_ready,
    input  logic                abort,
    output logic                busy,
    output logic                done
);

    if (NDIM < NDIM_MIN || NDIM > NDIM_MAX) begin : g_ndim_check
        $error("dma_agen_nd: NDIM out of supported range");
    end

    state_t              state, state_nxt;
    logic                done_r, done_set;
    logic                accept, fire, any_zero, last_beat;
    logic [AW-1:0]       addr_r, addr_nxt;
    logic [IFW-1:0]      info_r;
    logic [NDIM*SZW-1:0] size_r;
    logic [NDIM*STW-1:0] step_r;
    // Address at which each dim's current index began (lower dims at 0).
    logic [AW-1:0]       row_start [NDIM];
    logic [NDIM-1:0]     at_first, at_last, adv;

    function automatic logic [AW-1:0] sext_step(input logic [STW-1:0] raw);
        logic signed [STW-1:0] s;
        s = raw;
        return AW'(s);
    endfunction

    assign accept    = (state == IDLE) && start_valid;
    assign fire      = s_valid && s_ready;
    assign last_beat = fire && (&at_last);

    always_comb begin
        any_zero = 1'b0;
        for (int d = 0; d < NDIM; d++) begin
            if (dim_size[d*SZW +: SZW] == '0) any_zero = 1'b1;
        end
    end

    // Carry chain: dim d advances when all lower dims wrap on this beat.
    always_comb begin
        adv[0] = fire;
        for (int d = 1; d < NDIM; d++) begin
            adv[d] = adv[d-1] && at_last[d-1];
        end
    end

    // The highest advancing dim wins: its row start plus its step.
    always_comb begin
        addr_nxt = addr_r;
        for (int d = 0; d < NDIM; d++) begin
            if (adv[d]) addr_nxt = row_start[d] + sext_step(step_r[d*STW +: STW]);
        end
    end

    always_comb begin
        state_nxt = state;
        done_set  = 1'b0;
        case (state)
            IDLE: begin
                if (start_valid) begin
                    if (any_zero) done_set  = 1'b1;
                    else          state_nxt = RUN;
                end
            end
            RUN: begin
                if (abort || last_beat) begin
                    state_nxt = IDLE;
                    done_set  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            done_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_r <= done_set;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r <= '0;
            info_r <= '0;
            size_r <= '0;
            step_r <= '0;
            for (int d = 0; d < NDIM; d++) row_start[d] <= '0;
        end else if (accept) begin
            addr_r <= base;
            info_r <= m_info;
            size_r <= dim_size;
            step_r <= dim_step;
            for (int d = 0; d < NDIM; d++) row_start[d] <= base;
        end else if (fire) begin
            addr_r <= addr_nxt;
            for (int d = 0; d < NDIM; d++) begin
                if (adv[d]) row_start[d] <= addr_nxt;
            end
        end
    end

    for (genvar d = 0; d < NDIM; d++) begin : g_dim
        dma_dim_cnt #(.SZW(SZW)) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .clear    (accept),
            .adv      (adv[d]),
            .size     (size_r[d*SZW +: SZW]),
            .at_first (at_first[d]),
            .at_last  (at_last[d])
        );
    end

    // Flags are cumulative from dim 0 and forced low outside a job.
    always_comb begin
        logic f_acc, l_acc;
        f_acc   = 1'b1;
        l_acc   = 1'b1;
        s_first = '0;
        s_last  = '0;
        for (int d = 0; d < NDIM; d++) begin
            f_acc      = f_acc && at_first[d];
            l_acc      = l_acc && at_last[d];
            s_first[d] = f_acc && (state == RUN);
            s_last[d]  = l_acc && (state == RUN);
        end
    end

    assign start_ready = (state == IDLE);
    assign busy        = (state == RUN);
    assign s_valid     = (state == RUN);
    assign done        = done_r;
    assign s_addr      = addr_r;
    assign s_info      = info_r;

endmodule

// File: tb/tb_dma_agen_nd.sv
module tb_dma_agen_nd;

    localparam int AW   = 14;
    localparam int IFW  = 4;
    localparam int NDIM = 3;
    localparam int SZW  = 7;
    localparam int STW  = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic [AW-1:0]       base;
    logic [NDIM*SZW-1:0] dim_size;
    logic [NDIM*STW-1:0] dim_step;
    logic [IFW-1:0]      m_info;
    logic                start_valid;
    logic                start_ready;
    logic [AW-1:0]       s_addr;
    logic [IFW-1:0]      s_info;
    logic [NDIM-1:0]     s_first;
    logic [NDIM-1:0]     s_last;
    logic                s_valid;
    logic                s_ready = 1'b0;
    logic                abort;
    logic                busy;
    logic                done;

    dma_agen_nd #(.AW(AW), .IFW(IFW), .NDIM(NDIM), .SZW(SZW), .STW(STW)) dut (
        .clk         (clk),
        .rst         (rst),
        .base        (base),
        .dim_size    (dim_size),
        .dim_step    (dim_step),
        .m_info      (m_info),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .s_addr      (s_addr),
        .s_info      (s_info),
        .s_first     (s_first),
        .s_last      (s_last),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .abort       (abort),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]   addr;
        logic [IFW-1:0]  info;
        logic [NDIM-1:0] first;
        logic [NDIM-1:0] last;
    } beat_t;

    beat_t exp_q[$];
    int    chk_cnt  = 0;
    int    pass_cnt = 0;
    int    beat_cnt = 0;
    int    rdy_mode = 0;   // 0: always ready, 1: random backpressure

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        chk_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    function automatic int sx(input int raw);
        logic [31:0]           r;
        logic signed [STW-1:0] t;
        r = raw;
        t = r[STW-1:0];
        return int'(t);
    endfunction

    // Reference: beat n walks indices with dim 0 fastest; address is base plus
    // the sum of index*step over all dims, modulo 2^AW.
    task automatic push_job(input int b, input int sz[NDIM], input int st[NDIM], input int info);
        int    total, rem, a;
        int    idx [NDIM];
        logic  f, l;
        logic [31:0] av, iv;
        beat_t e;
        total = 1;
        for (int d = 0; d < NDIM; d++) total *= sz[d];
        for (int n = 0; n < total; n++) begin
            rem = n;
            a   = b;
            f   = 1'b1;
            l   = 1'b1;
            for (int d = 0; d < NDIM; d++) begin
                idx[d] = rem % sz[d];
                rem    = rem / sz[d];
                a     += idx[d] * sx(st[d]);
                f      = f && (idx[d] == 0);
                l      = l && (idx[d] == sz[d] - 1);
                e.first[d] = f;
                e.last[d]  = l;
            end
            av     = a;
            iv     = info;
            e.addr = av[AW-1:0];
            e.info = iv[IFW-1:0];
            exp_q.push_back(e);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake, and checks that a
    // stalled beat holds its address and flags into the next cycle.
    initial begin
        logic            prev_stall;
        logic [AW-1:0]   h_addr;
        logic [NDIM-1:0] h_first, h_last;
        beat_t           e;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_stall)
                check("stall_hold", {11'd0, s_valid, s_addr, s_first, s_last},
                      {11'd0, 1'b1, h_addr, h_first, h_last});
            if (s_valid && s_ready) begin
                if (exp_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL unexpected_beat: got addr 0x%0h, required no beat", s_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_addr", 32'(s_addr), 32'(e.addr));
                    check("beat_info_flags", {21'd0, s_info, s_first, s_last},
                          {21'd0, e.info, e.first, e.last});
                end
                beat_cnt++;
            end
            prev_stall = s_valid && !s_ready && !rst;
            h_addr     = s_addr;
            h_first    = s_first;
            h_last     = s_last;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) s_ready = 1'b1;
        else               s_ready = ($urandom_range(0, 2) != 0);
    end

    task automatic start_job(input int b, input int sz[NDIM], input int st[NDIM], input int info);
        logic [31:0] v;
        logic        zero;
        zero = 1'b0;
        for (int d = 0; d < NDIM; d++) if (sz[d] == 0) zero = 1'b1;
        if (!zero) push_job(b, sz, st, info);
        @(posedge clk); #1;
        v = b;    base   = v[AW-1:0];
        v = info; m_info = v[IFW-1:0];
        for (int d = 0; d < NDIM; d++) begin
            v = sz[d]; dim_size[d*SZW +: SZW] = v[SZW-1:0];
            v = st[d]; dim_step[d*STW +: STW] = v[STW-1:0];
        end
        start_valid = 1'b1;
        @(negedge clk);
        check("start_ready_at_start", 32'(start_ready), 32'd1);
        @(posedge clk); #1;
        start_valid = 1'b0;
    endtask

    task automatic wait_done(input logic zero);
        int waited;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!done && waited < 2000);
        check("done_seen", 32'(done), 32'd1);
        if (zero) begin
            check("zero_done_latency", waited, 1);
            check("zero_no_valid", 32'(s_valid), 32'd0);
            check("zero_start_ready", 32'(start_ready), 32'd1);
        end
        check("queue_drained", exp_q.size(), 0);
        @(negedge clk);
        check("done_one_cycle", {30'd0, done, busy}, 32'd0);
    endtask

    task automatic run_job(input int b, input int sz[NDIM], input int st[NDIM], input int info);
        logic zero;
        zero = 1'b0;
        for (int d = 0; d < NDIM; d++) if (sz[d] == 0) zero = 1'b1;
        start_job(b, sz, st, info);
        wait_done(zero);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        int sz[NDIM], st[NDIM];
        int b0, n, saw;

        rst = 1'b1; base = '0; dim_size = '0; dim_step = '0; m_info = '0;
        start_valid = 1'b0; abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {7'd0, s_valid, busy, done, s_addr, s_info, s_first, s_last}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(start_ready), 32'd1);

        // 2x3x2 walk, full throughput
        rdy_mode = 0;
        sz = '{2, 3, 2}; st = '{1, 'h10, 'h40};
        run_job('h100, sz, st, 5);

        // negative inner step wraps below zero
        sz = '{3, 1, 1}; st = '{'hFF, 0, 0};
        run_job('h0001, sz, st, 9);

        // same walk under random backpressure
        rdy_mode = 1;
        sz = '{2, 3, 2}; st = '{1, 'h10, 'h40};
        run_job('h100, sz, st, 3);

        // a zero-sized dimension produces no beats
        rdy_mode = 0;
        sz = '{4, 0, 2}; st = '{1, 2, 3};
        run_job('h055, sz, st, 1);

        // abort in the cycle the 5th beat is transferred
        sz = '{2, 3, 2}; st = '{1, 'h10, 'h40};
        b0 = beat_cnt;
        start_job('h200, sz, st, 7);
        n = 0;
        while (beat_cnt - b0 < 4 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_valid_low", 32'(s_valid), 32'd0);
        check("abort_done", 32'(done), 32'd1);
        check("abort_beats", beat_cnt - b0, 5);
        check("abort_remaining", exp_q.size(), 7);
        exp_q.delete();
        @(negedge clk);
        check("abort_done_one_cycle", 32'(done), 32'd0);
        sz = '{2, 2, 1}; st = '{2, 'h20, 0};
        run_job('h300, sz, st, 2);

        // abort while idle has no effect
        @(posedge clk); #1; abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        @(negedge clk);
        check("idle_abort_ignored", {29'd0, done, busy, start_ready}, 32'd1);

        // random jobs under backpressure
        rdy_mode = 1;
        for (int j = 0; j < 6; j++) begin
            for (int d = 0; d < NDIM; d++) begin
                sz[d] = $urandom_range(1, 3);
                st[d] = $urandom_range(0, 255);
            end
            run_job($urandom_range(0, (1 << AW) - 1), sz, st, $urandom_range(0, 15));
        end

        // reset in the middle of a job
        rdy_mode = 0;
        sz = '{4, 4, 2}; st = '{1, 8, 'h80};
        start_job('h123, sz, st, 6);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", {7'd0, s_valid, busy, done, s_addr, s_info, s_first, s_last}, 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_midjob_reset", 32'(start_ready), 32'd1);
        saw = 0;
        repeat (20) begin
            @(negedge clk);
            if (s_valid) saw++;
        end
        check("no_beats_after_reset", saw, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
